// File: rtl/adder_result_buffer.sv
// adder_result_buffer: show-ahead FIFO that captures {carry, sum} results from
// the upstream N-bit adder. It has valid/ready handshakes on both sides and
// keeps a saturating count of accepted results whose carry-out was set.
module adder_result_buffer #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_sum,
    input  logic                     in_carry,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_sum,
    output logic                     out_carry,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         carry_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Each entry is stored as {carry, sum}.
    logic [N:0]       mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CNT_W-1:0] carry_cnt_r;

    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;

    // The handshake qualifiers depend only on registered occupancy. This keeps
    // out_ready from reaching in_ready and in_valid from reaching out_valid.
    always_comb begin
        full_s  = (count_r == CW'(DEPTH));
        empty_s = (count_r == {CW{1'b0}});
        push_s  = in_valid && !full_s && !rst;
        pop_s   = out_ready && !empty_s && !rst;
    end

    // The storage array is deliberately left unreset. The head is gated to
    // zero whenever the buffer is empty, so stale contents never reach the
    // outputs.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {in_carry, in_sum};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy update. DEPTH is a power of two, so each pointer
    // wraps naturally from DEPTH-1 back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Carry-event counter. It counts only accepted pushes and holds at its
    // maximum value instead of wrapping around.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_cnt_r <= {CNT_W{1'b0}};
        end else if (push_s && in_carry && (carry_cnt_r != {CNT_W{1'b1}})) begin
            carry_cnt_r <= carry_cnt_r + CNT_W'(1);
        end else begin
            carry_cnt_r <= carry_cnt_r;
        end
    end

    // Show-ahead outputs, taken from the head entry. They read zero while the
    // buffer is empty.
    always_comb begin
        in_ready  = !full_s;
        out_valid = !empty_s;
        count     = count_r;
        carry_cnt = carry_cnt_r;
        out_sum   = {N{1'b0}};
        out_carry = 1'b0;
        if (!empty_s) begin
            out_sum   = mem_r[rd_ptr_r][N-1:0];
            out_carry = mem_r[rd_ptr_r][N];
        end else begin
            out_sum   = {N{1'b0}};
            out_carry = 1'b0;
        end
    end

    // Structural invariants of the buffer: occupancy is bounded, there is no
    // push while full and no pop while empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_r <= CW'(DEPTH));
            assert (!(push_s && (count_r == CW'(DEPTH))));
            assert (!(pop_s && (count_r == {CW{1'b0}})));
        end else begin
            assert (!push_s && !pop_s);
        end
    end

endmodule

// File: tb/tb_adder_result_buffer.sv
// Self-checking bench for adder_result_buffer. Two instances receive the same
// stimulus: one with CNT_W=16 and one with CNT_W=2, which exercises counter
// saturation. A queue-based reference model predicts the state after every
// edge, and a directed vector table pins down the key sequences.
module tb_adder_result_buffer;

    localparam int N     = 8;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [N-1:0] in_sum;
    logic         in_carry;
    logic         out_ready;

    logic         a_in_ready, a_out_valid, a_out_carry;
    logic [N-1:0] a_out_sum;
    logic [2:0]   a_count;
    logic [15:0]  a_carry_cnt;

    logic         b_in_ready, b_out_valid, b_out_carry;
    logic [N-1:0] b_out_sum;
    logic [2:0]   b_count;
    logic [1:0]   b_carry_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: an ideal FIFO queue plus an unbounded carry count.
    logic [N:0]  mq[$];
    int unsigned mcc;

    always #5 clk = ~clk;

    adder_result_buffer #(.N(N), .DEPTH(DEPTH), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_sum(in_sum), .in_carry(in_carry), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_sum(a_out_sum), .out_carry(a_out_carry),
        .count(a_count), .carry_cnt(a_carry_cnt)
    );

    adder_result_buffer #(.N(N), .DEPTH(DEPTH), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_sum(in_sum), .in_carry(in_carry), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_sum(b_out_sum), .out_carry(b_out_carry),
        .count(b_count), .carry_cnt(b_carry_cnt)
    );

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] sum;
        logic       c;
        logic       ordy;
        int         e_count;
        logic       e_ov;
        logic [7:0] e_sum;
        logic       e_c;
        int         e_cc;
        logic       e_ir;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(logic r, logic iv, logic [7:0] s, logic c, logic o,
                                int ec, logic eov, logic [7:0] es, logic e_c,
                                int ecc, logic eir);
        vec_t v;
        v.rst = r; v.iv = iv; v.sum = s; v.c = c; v.ordy = o;
        v.e_count = ec; v.e_ov = eov; v.e_sum = es; v.e_c = e_c;
        v.e_cc = ecc; v.e_ir = eir;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare both DUTs against the model's view of the state after the edge.
    task automatic check_model(input string tag);
        int          sz;
        logic [N:0]  head;
        int unsigned cca;
        int unsigned ccb;
        sz   = mq.size();
        head = (sz != 0) ? mq[0] : '0;
        cca  = (mcc > 65535) ? 65535 : mcc;
        ccb  = (mcc > 3) ? 3 : mcc;
        chk({tag, ".a_count"}, a_count, sz);
        chk({tag, ".a_in_ready"}, a_in_ready, sz != DEPTH);
        chk({tag, ".a_out_valid"}, a_out_valid, sz != 0);
        chk({tag, ".a_out_sum"}, a_out_sum, head[N-1:0]);
        chk({tag, ".a_out_carry"}, a_out_carry, head[N]);
        chk({tag, ".a_carry_cnt"}, a_carry_cnt, cca);
        chk({tag, ".b_count"}, b_count, sz);
        chk({tag, ".b_out_sum"}, b_out_sum, head[N-1:0]);
        chk({tag, ".b_carry_cnt"}, b_carry_cnt, ccb);
    endtask

    // Apply one cycle of stimulus, advance the model, then check after the edge.
    task automatic cycle(input logic r, input logic iv, input logic [7:0] s,
                         input logic c, input logic o, input string tag);
        bit do_push;
        bit do_pop;
        rst = r; in_valid = iv; in_sum = s; in_carry = c; out_ready = o;
        @(posedge clk);
        if (r) begin
            mq.delete();
            mcc = 0;
        end else begin
            do_push = iv && (mq.size() < DEPTH);
            do_pop  = o && (mq.size() > 0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back({c, s});
                if (c) mcc++;
            end
        end
        #1;
        check_model(tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sum = 8'h00; in_carry = 1'b0; out_ready = 1'b0;
        mcc = 0;

        // Directed vectors: rst, iv, sum, carry, out_ready -> state after the edge.
        tbl[0]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 0, 1'b1);
        tbl[1]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 0, 1'b1);
        tbl[2]  = mk(1'b0, 1'b1, 8'h2A, 1'b0, 1'b0, 1, 1'b1, 8'h2A, 1'b0, 0, 1'b1);
        tbl[3]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 0, 1'b1);
        tbl[4]  = mk(1'b0, 1'b1, 8'hFE, 1'b1, 1'b0, 1, 1'b1, 8'hFE, 1'b1, 1, 1'b1);
        tbl[5]  = mk(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 2, 1'b1, 8'hFE, 1'b1, 1, 1'b1);
        tbl[6]  = mk(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 3, 1'b1, 8'hFE, 1'b1, 2, 1'b1);
        tbl[7]  = mk(1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 4, 1'b1, 8'hFE, 1'b1, 3, 1'b0);
        tbl[8]  = mk(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 4, 1'b1, 8'hFE, 1'b1, 3, 1'b0);
        tbl[9]  = mk(1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 3, 1'b1, 8'h01, 1'b0, 3, 1'b1);
        tbl[10] = mk(1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 3, 1'b1, 8'hFF, 1'b1, 3, 1'b1);
        tbl[11] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2, 1'b1, 8'h10, 1'b1, 3, 1'b1);
        tbl[12] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b1, 8'h55, 1'b0, 3, 1'b1);
        tbl[13] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 3, 1'b1);
        tbl[14] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 3, 1'b1);
        tbl[15] = mk(1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1, 1'b1, 8'h33, 1'b1, 4, 1'b1);
        tbl[16] = mk(1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 2, 1'b1, 8'h33, 1'b1, 4, 1'b1);

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].rst, tbl[i].iv, tbl[i].sum, tbl[i].c, tbl[i].ordy, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.count", i), a_count, tbl[i].e_count);
            chk($sformatf("vec%0d.out_valid", i), a_out_valid, tbl[i].e_ov);
            chk($sformatf("vec%0d.out_sum", i), a_out_sum, tbl[i].e_sum);
            chk($sformatf("vec%0d.out_carry", i), a_out_carry, tbl[i].e_c);
            chk($sformatf("vec%0d.carry_cnt", i), a_carry_cnt, tbl[i].e_cc);
            chk($sformatf("vec%0d.in_ready", i), a_in_ready, tbl[i].e_ir);
        end

        // Steady state at occupancy 2: both pointers wrap and order is preserved.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 8'($urandom), 1'($urandom), 1'b1, "wrap");
            chk("wrap.count", a_count, 2);
        end

        // Saturation of the 2-bit counter, then a reset in mid-stream.
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "sat.rst");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 8'(8'hA0 + i), 1'b1, 1'b1, "sat.push");
        end
        chk("sat.b_carry_cnt", b_carry_cnt, 3);
        chk("sat.a_carry_cnt", a_carry_cnt, 5);
        cycle(1'b0, 1'b1, 8'hC1, 1'b1, 1'b0, "sat.fill");
        cycle(1'b0, 1'b1, 8'hC2, 1'b1, 1'b0, "sat.fill");
        chk("sat.b_carry_cnt_hold", b_carry_cnt, 3);
        chk("midrst.count_before", a_count, 3);
        cycle(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1, "midrst");
        chk("midrst.count", a_count, 0);
        chk("midrst.out_valid", a_out_valid, 0);
        chk("midrst.b_carry_cnt", b_carry_cnt, 0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "midrst.idle");
        chk("midrst.idle_valid", a_out_valid, 0);

        // Randomized traffic with occasional resets, checked against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 63) == 0), 1'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_result_buffer.md
Name: adder_result_buffer

Overview:
- Sequential stage directly downstream of the N-bit combinational adder.
- Captures each {carry, sum} result the adder produces into a small show-ahead FIFO with valid/ready on both sides, decoupling adder-side producers from slower consumers.
- Keeps a saturating count of accepted results whose carry-out was set, for overflow monitoring.

Parameters:
- N, 8, data width; must match the upstream adder's N.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the carry event counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents a result.
- in_ready  output  1  buffer can accept; equals !full.
- in_sum  input  N  adder sum.
- in_carry  input  1  adder carry-out.
- out_valid  output  1  head entry available; equals !empty.
- out_ready  input  1  consumer takes the head entry.
- out_sum  output  N  head entry sum; 0 when empty.
- out_carry  output  1  head entry carry; 0 when empty.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- carry_cnt  output  CNT_W  accepted entries with carry=1, saturating.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset:
  - While rst=1 at an edge, the next state is wr_ptr=0, rd_ptr=0, count=0 and carry_cnt=0. Storage array is not reset.
  - After reset: in_ready=1, out_valid=0, out_sum=0, out_carry=0.
  - Reset mid-operation flushes all entries. No push, pop or carry_cnt update occurs on a reset cycle.
- Push: occurs when in_valid && in_ready at an edge.
  - Writes {in_carry, in_sum} to mem[wr_ptr].
  - wr_ptr advances modulo DEPTH (wrap DEPTH-1 -> 0).
- Pop: occurs when out_valid && out_ready at an edge. rd_ptr advances modulo DEPTH.
- Show-ahead output:
  - out_sum/out_carry = mem[rd_ptr] whenever count>0, else 0.
  - An entry pushed into an empty buffer at edge t appears on the outputs after edge t, with out_valid=1 in cycle t+1 (latency 1). There is no combinational in->out bypass.
- Flags:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - Both are derived only from registered state. There is no combinational path from out_ready to in_ready or from in_valid to out_valid.
- Occupancy:
  - push only: +1.
  - pop only: -1.
  - push and pop together, or neither: unchanged.
- Full: in_ready=0. A simultaneous pop in that cycle does not enable a push; the freed slot becomes available next cycle.
- Empty: out_valid=0. An out_ready asserted while empty is ignored (no pointer move). A push into empty plus out_ready in the same cycle pops nothing.
- Upstream handshake: in_valid may drop without a push. Data is sampled only on a push edge. Held in_valid with new data each cycle is legal.
- carry_cnt:
  - +1 on each push with in_carry=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Unaffected by pops.
- Ordering: strict FIFO. No entry is dropped or duplicated.
- Assertions (Verilator-compatible, immediate, in always_ff):
  - count <= DEPTH.
  - No push when count==DEPTH.
  - No pop when count==0.

Test Plan:
- Reset, then idle -> in_ready=1, out_valid=0, out_sum=0x00, out_carry=0, count=0, carry_cnt=0.
- Push sum=0x2A carry=0 with out_ready=0 -> the following cycle shows out_valid=1, out_sum=0x2A, out_carry=0, count=1. Then raise out_ready for 1 cycle -> out_valid=0, count=0.
- Push 0xFE/1, 0x01/0, 0xFF/1, 0x10/1 with out_ready=0 -> count=4, in_ready=0, carry_cnt=3. A 5th in_valid held with 0x55 is not accepted. Draining yields FE/1, 01/0, FF/1, 10/1 in that order.
- When full, in_valid=1 and out_ready=1 together -> that cycle pops only (count 4->3); next cycle push accepted (count 3->3 with continued pop).
- 10 pushes interleaved with pops at count=2 (continuous in_valid/out_ready) -> pointers wrap, count stays 2, output sequence equals input sequence.
- CNT_W=2: push 5 entries with carry=1 (draining as needed) -> carry_cnt reads 3 and stays 3. Asserting rst mid-stream with count=3 -> next cycle count=0, out_valid=0, carry_cnt=0, and the entries are lost.
